// File: rtl/ram_dp_param_if.sv
// rtl/ram_dp_param_if.sv - request/response bundle for ram_dp_param
interface ram_dp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wbe;
  logic                  rd_en;
  logic [ADDR_W-1:0]     raddr;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  addr_err;
  logic                  busy;

  modport master (
    output wr_en, waddr, wdata, wbe, rd_en, raddr,
    input  rdata, rvalid, addr_err, busy
  );

  modport slave (
    input  wr_en, waddr, wdata, wbe, rd_en, raddr,
    output rdata, rvalid, addr_err, busy
  );
endinterface

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - parametrised simple dual-port RAM with byte enables and 1/2-cycle reads
// Optional macro RAM_CLEAR_ON_RESET_EN adds a post-reset zeroing sweep that holds busy high.
module ram_dp_param #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  ram_dp_param_if.slave bus
);
  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy_w;
  logic              clr_we;
  logic [IDX_W-1:0]  clr_idx;
  logic              wr_in, rd_in, wr_ok, rd_ok, err_d;
  logic [DATA_W-1:0] rd_word_d;
  logic [DATA_W-1:0] s1_data_q, rdata_q;
  logic              s1_valid_q, rvalid_q, err_q;

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == S_CLEAR) begin
      if (cnt_q == LAST_C) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy_w  = busy_q;
  assign clr_we  = (state_q == S_CLEAR) && !rst;
  assign clr_idx = cnt_q[IDX_W-1:0];
`else
  assign busy_w  = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Requests are widened by one bit so DEPTH == 2**ADDR_W still compares correctly
  assign wr_in = ({1'b0, bus.waddr} < DEPTH_C);
  assign rd_in = ({1'b0, bus.raddr} < DEPTH_C);
  assign wr_ok = bus.wr_en && wr_in && !busy_w && !rst;
  assign rd_ok = bus.rd_en && !busy_w && !rst;
  assign err_d = !busy_w && ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in));

  always_comb begin
    rd_word_d = '0;
    if (rd_in) begin
      rd_word_d = mem_q[bus.raddr[IDX_W-1:0]];
      if ((WRITE_FIRST != 0) && wr_ok && (bus.waddr == bus.raddr)) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wbe[i]) rd_word_d[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) mem_q[bus.waddr[IDX_W-1:0]][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Reset flushes both pipeline stages so an in-flight read never surfaces
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= err_d;
      s1_valid_q <= rd_ok;
      if (rd_ok) s1_data_q <= rd_word_d;
      if (RD_LAT == 2) begin
        rvalid_q <= s1_valid_q;
        if (s1_valid_q) rdata_q <= s1_data_q;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= rd_word_d;
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.addr_err = err_q;
  assign bus.busy     = busy_w;
endmodule

// File: tb/tb_ram_dp_param.sv
// tb/tb_ram_dp_param.sv - directed vector bench over four ram_dp_param configurations
module tb_ram_dp_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en_s = 1'b0;
  logic [2:0]  waddr_s = '0;
  logic [31:0] wdata_s = '0;
  logic [3:0]  wbe_s   = '0;
  logic        rd_en_s = 1'b0;
  logic [2:0]  raddr_s = '0;

  int total = 0;
  int bad   = 0;

  // if0: 8b x8 write-first, if1: 8b x8 read-first, if2: 32b x6, if3: 8b x8 two-cycle read
  ram_dp_param_if #(.DATA_W(8),  .ADDR_W(3)) if0 ();
  ram_dp_param_if #(.DATA_W(8),  .ADDR_W(3)) if1 ();
  ram_dp_param_if #(.DATA_W(32), .ADDR_W(3)) if2 ();
  ram_dp_param_if #(.DATA_W(8),  .ADDR_W(3)) if3 ();

  assign if0.wr_en = wr_en_s; assign if0.waddr = waddr_s; assign if0.wdata = wdata_s[7:0];
  assign if0.wbe   = wbe_s[0]; assign if0.rd_en = rd_en_s; assign if0.raddr = raddr_s;
  assign if1.wr_en = wr_en_s; assign if1.waddr = waddr_s; assign if1.wdata = wdata_s[7:0];
  assign if1.wbe   = wbe_s[0]; assign if1.rd_en = rd_en_s; assign if1.raddr = raddr_s;
  assign if2.wr_en = wr_en_s; assign if2.waddr = waddr_s; assign if2.wdata = wdata_s;
  assign if2.wbe   = wbe_s;    assign if2.rd_en = rd_en_s; assign if2.raddr = raddr_s;
  assign if3.wr_en = wr_en_s; assign if3.waddr = waddr_s; assign if3.wdata = wdata_s[7:0];
  assign if3.wbe   = wbe_s[0]; assign if3.rd_en = rd_en_s; assign if3.raddr = raddr_s;

  ram_dp_param #(.DATA_W(8),  .DEPTH(8), .ADDR_W(3), .RD_LAT(1), .WRITE_FIRST(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  ram_dp_param #(.DATA_W(8),  .DEPTH(8), .ADDR_W(3), .RD_LAT(1), .WRITE_FIRST(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  ram_dp_param #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .RD_LAT(1), .WRITE_FIRST(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  ram_dp_param #(.DATA_W(8),  .DEPTH(8), .ADDR_W(3), .RD_LAT(2), .WRITE_FIRST(1))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    int          dut;
    logic        wr;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rd;
    logic [2:0]  ra;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int d, logic w, logic [2:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic r, logic [2:0] ra, logic ev, logic [31:0] ed, logic ee);
    vec_t v;
    v.dut = d; v.wr = w; v.wa = wa; v.wd = wd; v.be = be;
    v.rd = r; v.ra = ra; v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic sample(input int d, output logic rv, output logic [31:0] rd,
                        output logic er, output logic bz);
    case (d)
      0:       begin rv = if0.rvalid; rd = {24'h0, if0.rdata}; er = if0.addr_err; bz = if0.busy; end
      1:       begin rv = if1.rvalid; rd = {24'h0, if1.rdata}; er = if1.addr_err; bz = if1.busy; end
      2:       begin rv = if2.rvalid; rd = if2.rdata;          er = if2.addr_err; bz = if2.busy; end
      default: begin rv = if3.rvalid; rd = {24'h0, if3.rdata}; er = if3.addr_err; bz = if3.busy; end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic r, input logic [2:0] ra);
    @(negedge clk);
    wr_en_s = w; waddr_s = wa; wdata_s = wd; wbe_s = be; rd_en_s = r; raddr_s = ra;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic rv, er, bz;
    logic [31:0] rd;
    int n;
    n = 0;
    sample(0, rv, rd, er, bz);
    while (bz && n < 64) begin
      step();
      sample(0, rv, rd, er, bz);
      n++;
    end
    check("idle_wait", {31'h0, bz}, 32'h0);
  endtask

  logic        rv, er, bz;
  logic [31:0] rd;
  logic [7:0]  wvals [8];
  logic        exp_busy;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvals[0] = 8'd40; wvals[1] = 8'd21; wvals[2] = 8'd42; wvals[3] = 8'd35;
    wvals[4] = 8'd46; wvals[5] = 8'd59; wvals[6] = 8'd66; wvals[7] = 8'd17;

    for (int i = 0; i < 8; i++) vt.push_back(mk(0, 1, 3'(i), {24'h0, wvals[i]}, 4'hF, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vt.push_back(mk(0, 0, 0, 0, 0, 1, 3'(i), 1, {24'h0, wvals[i]}, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 1, 3, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 1, 3, 32'h11223344, 4'h5, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 0, 0, 0, 1, 3, 1, 32'hAA22CC44, 0));
    vt.push_back(mk(2, 1, 3, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 0, 0, 0, 1, 3, 1, 32'hAA22CC44, 0));
    vt.push_back(mk(2, 1, 7, 32'hDEADBEEF, 4'hF, 1, 6, 1, 32'h0, 1));
    vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 1, 6, 32'h12345678, 4'hF, 0, 0, 0, 0, 1));
    vt.push_back(mk(2, 0, 0, 0, 0, 1, 5, 1, 32'h0000003B, 0));
    vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 1, 5, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 32'h3B, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 1, 1, 1, 32'd40, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 32'd21, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef RAM_CLEAR_ON_RESET_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif

    step();
    step();
    for (int d = 0; d < 4; d++) begin
      sample(d, rv, rd, er, bz);
      check($sformatf("reset_rvalid%0d", d), {31'h0, rv}, 32'h0);
      check($sformatf("reset_rdata%0d", d), rd, 32'h0);
      check($sformatf("reset_err%0d", d), {31'h0, er}, 32'h0);
      check($sformatf("reset_busy%0d", d), {31'h0, bz}, {31'h0, exp_busy});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    wait_idle();

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].wr, vt[k].wa, vt[k].wd, vt[k].be, vt[k].rd, vt[k].ra);
      step();
      sample(vt[k].dut, rv, rd, er, bz);
      check($sformatf("vec%0d_rvalid", k), {31'h0, rv}, {31'h0, vt[k].ev});
      check($sformatf("vec%0d_err", k), {31'h0, er}, {31'h0, vt[k].ee});
      if (vt[k].ev) check($sformatf("vec%0d_rdata", k), rd, vt[k].ed);
    end

    // Same-edge read and write of address 2: write-first vs read-first instances
    drive(1, 2, 32'h2A, 4'hF, 0, 0);
    step();
    drive(1, 2, 32'h5A, 4'hF, 1, 2);
    step();
    sample(0, rv, rd, er, bz);
    check("rdw_wf_rvalid", {31'h0, rv}, 32'h1);
    check("rdw_wf_rdata", rd, 32'h5A);
    sample(1, rv, rd, er, bz);
    check("rdw_rf_rvalid", {31'h0, rv}, 32'h1);
    check("rdw_rf_rdata", rd, 32'h2A);
    drive(0, 0, 0, 0, 1, 2);
    step();
    sample(1, rv, rd, er, bz);
    check("rdw_rf_after", rd, 32'h5A);
    drive(0, 0, 0, 0, 0, 0);
    step();
    sample(0, rv, rd, er, bz);
    check("rdw_idle_rvalid", {31'h0, rv}, 32'h0);

    // Two-cycle read instance: reset while reads are in flight
    drive(0, 0, 0, 0, 1, 0);
    step();
    sample(3, rv, rd, er, bz);
    check("midrst_rv0", {31'h0, rv}, 32'h0);
    @(negedge clk);
    rd_en_s = 1'b1; raddr_s = 3'd1; rst = 1'b1;
    step();
    sample(3, rv, rd, er, bz);
    check("midrst_rv1", {31'h0, rv}, 32'h0);
    check("midrst_rdata", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0; rd_en_s = 1'b0;
    step();
    sample(3, rv, rd, er, bz);
    check("midrst_rv2", {31'h0, rv}, 32'h0);
    step();
    sample(3, rv, rd, er, bz);
    check("midrst_rv3", {31'h0, rv}, 32'h0);
    check("midrst_err", {31'h0, er}, 32'h0);
    wait_idle();

`ifdef RAM_CLEAR_ON_RESET_EN
    begin
      int   nb;
      logic rv_seen;
      nb = 0;
      rv_seen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      @(negedge clk);
      rst = 1'b0; rd_en_s = 1'b1; raddr_s = 3'd1;
      sample(0, rv, rd, er, bz);
      if (bz) nb = 1;
      for (int g = 0; g < 40 && bz; g++) begin
        step();
        sample(0, rv, rd, er, bz);
        if (rv || er) rv_seen = 1'b1;
        if (bz) nb++;
      end
      rd_en_s = 1'b0;
      check("clr_busy_cycles", 32'(nb), 32'd8);
      check("clr_no_rvalid", {31'h0, rv_seen}, 32'h0);
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 0, 0, 1, 3'(i));
        step();
        sample(0, rv, rd, er, bz);
        check($sformatf("clr_rd%0d_rvalid", i), {31'h0, rv}, 32'h1);
        check($sformatf("clr_rd%0d_rdata", i), rd, 32'h0);
      end
      drive(0, 0, 0, 0, 0, 0);
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
- Parametrised simple dual-port RAM: one write port and one read port, both synchronous to a single clock.
- Successor to the fixed 8x8 read/write RAM used behind interface-task benches.
- Adds over its predecessor: configurable width/depth, independent read/write enables, byte enables, selectable read latency, read-valid strobe, read-during-write policy, out-of-range address detection.
- Sits behind a bus interface; read and write transactions may be issued every cycle.

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8.
- DEPTH, 8: number of words; need not be a power of two; must be >= 2.
- ADDR_W, 8: address port width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- WRITE_FIRST, 1: same-address read-during-write policy. 1 = read returns the new data; 0 = read returns the old data.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst, input, 1: synchronous active-high reset.
- wr_en, input, 1: write request this cycle.
- waddr, input, ADDR_W: write address.
- wdata, input, DATA_W: write data.
- wbe, input, DATA_W/8: byte enables; bit i qualifies wdata[8i+7:8i].
- rd_en, input, 1: read request this cycle.
- raddr, input, ADDR_W: read address.
- rdata, output, DATA_W: read data; valid when rvalid=1.
- rvalid, output, 1: read data strobe, high for one cycle per accepted read.
- addr_err, output, 1: registered pulse, high the cycle after any request with address >= DEPTH.
- busy, output, 1: high while requests are not accepted (tied 0 unless optional feature is enabled).

Behaviour:
- Reset (rst=1 at posedge): rdata=0, rvalid=0, addr_err=0, busy=0, read pipeline flushed. Memory contents are NOT altered.
- A read or write presented in the same cycle as rst=1 is dropped; no memory update and no rvalid.
- Write: at posedge with wr_en=1 and waddr<DEPTH, for each i with wbe[i]=1, mem[waddr] byte i <= wdata byte i. Bytes with wbe[i]=0 are unchanged. wbe=0 performs no update and raises no error.
- Read: rd_en=1 sampled at posedge N.
  - RD_LAT=1: rdata and rvalid=1 presented after edge N.
  - RD_LAT=2: rdata passes through one additional output register; rvalid rises after edge N+1.
  - Back-to-back reads give one rvalid per read, in order, with no bubbles.
- rvalid=0 in any cycle with no read completing. rdata holds its last value when rvalid=0; a consumer must not rely on it.
- Out-of-range read (raddr>=DEPTH): rvalid still asserts at normal latency; rdata=0.
- Out-of-range write (waddr>=DEPTH): memory unchanged.
- addr_err: high for one cycle after any out-of-range request, read or write. Both ports bad in the same cycle gives a single pulse.
- Read-during-write, same address, same edge:
  - WRITE_FIRST=1: rdata is the merged word (enabled bytes new, other bytes old).
  - WRITE_FIRST=0: rdata is the pre-write word.
- Read-during-write, different addresses: fully independent.
- Simultaneous write and read to an out-of-range address: both ignored as above; one addr_err pulse.
- Reset mid-read (RD_LAT=2, rst asserted with one read in flight): the in-flight read is discarded; no rvalid follows.

Optional Feature:
- Macro: RAM_CLEAR_ON_RESET_EN.
- Defined:
  - A two-state FSM (IDLE, CLEAR) is added, with a clear counter of width ADDR_W.
  - rst=1 forces CLEAR, counter=0, busy=1.
  - Each cycle in CLEAR, after rst deasserts: mem[counter] <= 0, counter increments.
  - After location DEPTH-1 is written: state returns to IDLE and busy=0.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - While busy=1, wr_en and rd_en are ignored: no rvalid, no addr_err.
  - rst reasserted during CLEAR restarts the sweep from 0.
- Not defined: FSM and counter are absent; busy is tied to 0; memory is uninitialised (X in simulation) until written.

Test Plan:
- DATA_W=8, DEPTH=8, RD_LAT=1: write 40,21,42,35,46,59,66,17 to addresses 0..7, then read 0..7 back-to-back -> rvalid high for 8 consecutive cycles; rdata = 40,21,42,35,46,59,66,17 in order.
- DATA_W=32: write 0xAABBCCDD to addr 3, then write 0x11223344 to addr 3 with wbe=4'b0101, then read addr 3 -> rdata=0xAA22CC44.
- Same-edge write 0x5A and read, both addr 2, where mem[2]=0x2A -> rdata=0x5A with WRITE_FIRST=1; rdata=0x2A with WRITE_FIRST=0.
- DEPTH=6: write addr 7 and read addr 6 -> memory unchanged, rdata=0 with rvalid=1, addr_err high for exactly one cycle.
- RD_LAT=2: read issued at cycle N -> rvalid at N+2; a second read with rst at N+1 -> no rvalid for either read; rdata=0.
- RAM_CLEAR_ON_RESET_EN, DEPTH=8: rst 1 cycle with mem preloaded -> busy high for 8 cycles; rd_en during busy gives no rvalid; reads of 0..7 afterwards return 0.
